mem_subsys_ctrl: RTL and testbench

Memory subsystem control block: an IO-mapped register file, written by the CPU, that sequences reset, flush and prefetch-enable for the program cache (port 1) and the data cache (port 2) and holds one page register per cache. Cache reset and flush are issued only at a quiescent point, when that cache has no outstanding SDRAM request, so an in-flight transaction is never torn. It sits between the CPU IO bus (decoded at 0xFFF8–0xFFFB) and the two cache controllers.

---
 rtl/msc_pkg.sv | 25 ++
 rtl/mem_subsys_ctrl_if.sv | 35 +++
 rtl/msc_channel.sv | 105 ++++++++++
 rtl/mem_subsys_ctrl.sv | 86 ++++++++
 tb/tb_mem_subsys_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/msc_pkg.sv
// Shared definitions for the memory subsystem control block.
// Register index map, control bit positions and the per-channel sequencer states.
// No logic; imported by every file of mem_subsys_ctrl.
package msc_pkg;

    // Register select values on the IO bus (A[1:0]).
    localparam logic [1:0] CTRL_P1 = 2'd0;
    localparam logic [1:0] PAGE_P1 = 2'd1;
    localparam logic [1:0] CTRL_P2 = 2'd2;
    localparam logic [1:0] PAGE_P2 = 2'd3;

    // Bit positions inside a control register write.
    localparam int BIT_RST   = 0;
    localparam int BIT_FLUSH = 1;
    localparam int BIT_PF    = 2;
    localparam int BIT_EN    = 3;

    // Channel sequencer: wait for a quiescent cache, then pulse.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Q = 2'd1,
        PULSE  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/mem_subsys_ctrl_if.sv
// CPU IO write port plus both cache controller connections of mem_subsys_ctrl.
// Pure wiring, zero latency.
// No backpressure on the write side; req holds off cache commands, ready is observation only.
interface mem_subsys_ctrl_if;

    logic       wren;
    logic [1:0] A;
    logic [7:0] data;

    logic [7:0] p1_page;
    logic [7:0] p2_page;
    logic       p1_reset;
    logic       p2_reset;
    logic       p1_prefetch;
    logic       p2_prefetch;
    logic       p2_flush;

    logic       p1_req;
    logic       p2_req;
    logic       p1_ready;
    logic       p2_ready;

    // CPU and cache side: drives the write strobe and the cache request status.
    modport master (
        output wren, A, data, p1_req, p2_req, p1_ready, p2_ready,
        input  p1_page, p2_page, p1_reset, p2_reset, p1_prefetch, p2_prefetch, p2_flush
    );

    // Control block side.
    modport slave (
        input  wren, A, data, p1_req, p2_req, p1_ready, p2_ready,
        output p1_page, p2_page, p1_reset, p2_reset, p1_prefetch, p2_prefetch, p2_flush
    );

endinterface

// File: rtl/msc_channel.sv
// One cache channel: latches reset/flush commands, waits for req=0, then emits a registered pulse.
// Latency: pulse asserts after the second edge following the write when req=0; prefetch after one edge.
// Backpressure: req=1 stalls the pulse indefinitely; commands written while busy are dropped.
// Build option MSC_PREFETCH_EN: when undefined the prefetch output is tied low.
module msc_channel
    import msc_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter bit FLUSH_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ctrl_wr,
    input  logic cmd_rst,
    input  logic cmd_flush,
    input  logic cmd_pf,
    input  logic req,
    output logic cache_reset,
    output logic cache_flush,
    output logic prefetch
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_rst_q, is_rst_d;
    logic             reset_q, reset_d;
    logic             flush_q, flush_d;
    logic             pf_q, pf_d;

    // Next state, pulse length counter and registered pulse outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_rst_d = is_rst_q;
        case (state_q)
            IDLE: begin
                // Reset wins over flush when both are requested.
                if (ctrl_wr && (cmd_rst || (FLUSH_EN && cmd_flush))) begin
                    state_d  = WAIT_Q;
                    is_rst_d = cmd_rst;
                end
            end
            WAIT_Q: begin
                if (!req) begin
                    state_d = PULSE;
                    cnt_d   = is_rst_q ? CNT_W'(RESET_CYCLES - 1) : '0;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        reset_d = (state_d == PULSE) && is_rst_d;
        flush_d = FLUSH_EN && (state_d == PULSE) && !is_rst_d;
    end

`ifdef MSC_PREFETCH_EN
    // Prefetch level follows every enabled control write, busy or not.
    always_comb begin
        pf_d = pf_q;
        if (ctrl_wr) begin
            pf_d = cmd_pf;
        end
    end
`else
    logic unused_pf;
    assign unused_pf = cmd_pf;

    // Prefetch support not built: level stays low.
    always_comb begin
        pf_d = 1'b0;
    end
`endif

    // State and output registers; the cache is held in reset with the system.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_rst_q <= 1'b0;
            reset_q  <= 1'b1;
            flush_q  <= 1'b0;
            pf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_rst_q <= is_rst_d;
            reset_q  <= reset_d;
            flush_q  <= flush_d;
            pf_q     <= pf_d;
        end
    end

    assign cache_reset = reset_q;
    assign cache_flush = flush_q;
    assign prefetch    = pf_q;

endmodule

// File: rtl/mem_subsys_ctrl.sv
// IO-mapped control for program (P1) and data (P2) caches: page registers plus reset/flush/prefetch.
// Latency: page and prefetch one edge after the write; cache pulses after req=0 is seen.
// Backpressure: none on the IO write; cache req defers reset/flush. Option macro MSC_PREFETCH_EN.
module mem_subsys_ctrl
    import msc_pkg::*;
#(
    parameter int RESET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_subsys_ctrl_if.slave  bus
);

    logic [7:0] p1_page_q, p1_page_d;
    logic [7:0] p2_page_q, p2_page_d;
    logic       p1_ctrl_wr;
    logic       p2_ctrl_wr;
    logic       unused_ready;
    logic       unused_p1_flush;

    // ready is carried for port compatibility only.
    assign unused_ready = bus.p1_ready | bus.p2_ready;

    // Control writes without the enable bit are discarded here.
    assign p1_ctrl_wr = bus.wren && (bus.A == CTRL_P1) && bus.data[BIT_EN];
    assign p2_ctrl_wr = bus.wren && (bus.A == CTRL_P2) && bus.data[BIT_EN];

    // Page registers load on any write to their index, independent of the channels.
    always_comb begin
        p1_page_d = p1_page_q;
        p2_page_d = p2_page_q;
        if (bus.wren && (bus.A == PAGE_P1)) begin
            p1_page_d = bus.data;
        end
        if (bus.wren && (bus.A == PAGE_P2)) begin
            p2_page_d = bus.data;
        end
    end

    // Page register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_page_q <= 8'h00;
            p2_page_q <= 8'h00;
        end else begin
            p1_page_q <= p1_page_d;
            p2_page_q <= p2_page_d;
        end
    end

    assign bus.p1_page = p1_page_q;
    assign bus.p2_page = p2_page_q;

    msc_channel #(
        .RESET_CYCLES (RESET_CYCLES),
        .FLUSH_EN     (1'b0)
    ) u_p1 (
        .clk         (clk),
        .rst         (rst),
        .ctrl_wr     (p1_ctrl_wr),
        .cmd_rst     (bus.data[BIT_RST]),
        .cmd_flush   (bus.data[BIT_FLUSH]),
        .cmd_pf      (bus.data[BIT_PF]),
        .req         (bus.p1_req),
        .cache_reset (bus.p1_reset),
        .cache_flush (unused_p1_flush),
        .prefetch    (bus.p1_prefetch)
    );

    msc_channel #(
        .RESET_CYCLES (RESET_CYCLES),
        .FLUSH_EN     (1'b1)
    ) u_p2 (
        .clk         (clk),
        .rst         (rst),
        .ctrl_wr     (p2_ctrl_wr),
        .cmd_rst     (bus.data[BIT_RST]),
        .cmd_flush   (bus.data[BIT_FLUSH]),
        .cmd_pf      (bus.data[BIT_PF]),
        .req         (bus.p2_req),
        .cache_reset (bus.p2_reset),
        .cache_flush (bus.p2_flush),
        .prefetch    (bus.p2_prefetch)
    );

endmodule

// File: tb/tb_mem_subsys_ctrl.sv
// Testbench for mem_subsys_ctrl: directed IO writes, expected output changes queued as they are issued.
// A monitor compares every observed output change against the head of the queue (cycle and value).
// Honours MSC_PREFETCH_EN the same way the design does.
module tb_mem_subsys_ctrl;

    typedef struct {
        int          cyc;
        logic [20:0] vec;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    bit   mon_en;

    exp_t        exp_q[$];
    logic [20:0] last_vec;

    // Model of the outputs, updated by the stimulus before each push.
    logic [7:0] m_p1_page, m_p2_page;
    logic       m_p1_reset, m_p2_reset, m_p1_pf, m_p2_pf, m_p2_flush;

    mem_subsys_ctrl_if bus ();

    mem_subsys_ctrl #(.RESET_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] out_vec();
        return {bus.p1_page, bus.p2_page, bus.p1_reset, bus.p2_reset,
                bus.p1_prefetch, bus.p2_prefetch, bus.p2_flush};
    endfunction

    function automatic logic [20:0] model_vec();
        return {m_p1_page, m_p2_page, m_p1_reset, m_p2_reset, m_p1_pf, m_p2_pf, m_p2_flush};
    endfunction

    task automatic push(input int c);
        exp_t e;
        e.cyc = c;
        e.vec = model_vec();
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_p1_page  = 8'h00;
        m_p2_page  = 8'h00;
        m_p1_reset = 1'b1;
        m_p2_reset = 1'b1;
        m_p1_pf    = 1'b0;
        m_p2_pf    = 1'b0;
        m_p2_flush = 1'b0;
    endtask

    // Called at a negedge; returns the edge number at which the write is sampled.
    task automatic wr(input logic [1:0] a, input logic [7:0] d, output int n);
        bus.wren = 1'b1;
        bus.A    = a;
        bus.data = d;
        n        = cyc + 1;
        @(negedge clk);
        bus.wren = 1'b0;
        bus.A    = 2'd0;
        bus.data = 8'h00;
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Monitor: every change of the output vector must match the next expected change.
    always @(negedge clk) begin
        logic [20:0] cur;
        exp_t        e;
        if (mon_en) begin
            cur = out_vec();
            if (cur !== last_vec) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== cur) begin
                        failures++;
                        $display("FAIL output_change got cyc=%0d vec=%h expected cyc=%0d vec=%h",
                                 cyc, cur, e.cyc, e.vec);
                    end
                end
                last_vec = cur;
            end
        end
    end

    initial begin
        int n;
        int m;
        int n2;
        cyc          = 0;
        checks       = 0;
        failures     = 0;
        mon_en       = 1'b0;
        rst          = 1'b1;
        bus.wren     = 1'b0;
        bus.A        = 2'd0;
        bus.data     = 8'h00;
        bus.p1_req   = 1'b0;
        bus.p2_req   = 1'b0;
        bus.p1_ready = 1'b0;
        bus.p2_ready = 1'b0;
        model_reset();

        // Reset state while rst is held for three cycles.
        tick(3);
        checks++;
        if (out_vec() !== model_vec()) begin
            failures++;
            $display("FAIL reset_state got=%h expected=%h", out_vec(), model_vec());
        end
        last_vec = out_vec();
        mon_en   = 1'b1;

        // Release: both cache resets drop on the first edge.
        rst        = 1'b0;
        m_p1_reset = 1'b0;
        m_p2_reset = 1'b0;
        push(cyc + 1);
        tick(2);

        // Page writes.
        wr(2'd1, 8'h5A, n);
        m_p1_page = 8'h5A;
        push(n);
        wr(2'd3, 8'hC3, n);
        m_p2_page = 8'hC3;
        push(n);
        tick(1);

        // Quiescent P1 reset: high after edge n+1 for two cycles; pages untouched.
        wr(2'd0, 8'h09, n);
        m_p1_reset = 1'b1;
        push(n + 1);
        m_p1_reset = 1'b0;
        push(n + 3);
        tick(4);

        // Deferred P2 flush: held off while req=1, single cycle once req falls.
        bus.p2_req = 1'b1;
        tick(1);
        wr(2'd2, 8'h0A, n);
        tick(3);
        bus.p2_req = 1'b0;
        m          = cyc + 1;
        m_p2_flush = 1'b1;
        push(m);
        m_p2_flush = 1'b0;
        push(m + 1);
        tick(4);

        // Control write without enable bit: nothing happens.
        wr(2'd2, 8'h07, n);
        tick(3);

        // Reset and flush together: reset only.
        wr(2'd2, 8'h0B, n);
        m_p2_reset = 1'b1;
        push(n + 1);
        m_p2_reset = 1'b0;
        push(n + 3);
        tick(4);

        // Flush bit on P1 is ignored.
        wr(2'd0, 8'h0A, n);
        tick(3);

        // Prefetch on and off for P1, no reset pulse.
        wr(2'd0, 8'h0C, n);
`ifdef MSC_PREFETCH_EN
        m_p1_pf = 1'b1;
        push(n);
`endif
        tick(2);
        wr(2'd0, 8'h08, n);
`ifdef MSC_PREFETCH_EN
        m_p1_pf = 1'b0;
        push(n);
`endif
        tick(2);

        // Command while busy is dropped but its prefetch bit still lands.
        bus.p2_req = 1'b1;
        wr(2'd2, 8'h09, n);
        wr(2'd2, 8'h0E, n2);
`ifdef MSC_PREFETCH_EN
        m_p2_pf = 1'b1;
        push(n2);
`endif
        tick(2);
        bus.p2_req = 1'b0;
        m          = cyc + 1;
        m_p2_reset = 1'b1;
        push(m);
        m_p2_reset = 1'b0;
        push(m + 2);
        tick(5);

        // rst during a pending flush: everything back to reset values, flush discarded.
        bus.p2_req = 1'b1;
        wr(2'd2, 8'h0A, n);
        m = cyc;
        #2;
        rst = 1'b1;
        model_reset();
        push(m + 1);
        tick(2);
        rst        = 1'b0;
        bus.p2_req = 1'b0;
        m_p1_reset = 1'b0;
        m_p2_reset = 1'b0;
        push(cyc + 1);
        tick(6);

        // Every queued change must have been seen.
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_changes got=%0d pending expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
